// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: FSM states, field_sel encoding and adjust-pulse indices for clock_set_ctrl.
`default_nettype none

package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam int ADJ_UP_H   = 0;
  localparam int ADJ_DOWN_H = 1;
  localparam int ADJ_UP_M   = 2;
  localparam int ADJ_DOWN_M = 3;
  localparam int ADJ_UP_S   = 4;
  localparam int ADJ_DOWN_S = 5;

  function automatic state_t advance(input state_t s);
    case (s)
      RUN:     return SET_H;
      SET_H:   return SET_M;
      SET_M:   return SET_S;
      default: return RUN;
    endcase
  endfunction

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      SET_H:   return FIELD_HOUR;
      SET_M:   return FIELD_MIN;
      SET_S:   return FIELD_SEC;
      default: return FIELD_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer, registered rising-edge press, optional auto-repeat
// (auto-repeat built only when CLOCK_SET_AUTOREPEAT_EN is defined).
`default_nettype none

module btn_sync_edge #(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic repeat_en,
  output logic press
);

  logic sync1, sync2, sync2_d;
  logic valid1, valid2;
  logic armed;
  logic edge_hit;

  // armed only once the synchronizer has seen the button low after reset,
  // so a button held through reset release never counts as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      valid1  <= 1'b0;
      valid2  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      sync2_d <= sync2;
      valid1  <= 1'b1;
      valid2  <= valid1;
      armed   <= armed | (valid2 & ~sync2);
    end
  end

  assign edge_hit = sync2 & ~sync2_d & armed;

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);

  logic             rpt_active;
  logic             rpt_phase;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_hold;
  logic             rpt_fire;

  assign rpt_hold = rpt_active & sync2 & repeat_en;
  assign rpt_fire = rpt_hold & (rpt_cnt == (rpt_phase ? RPT_W'(REPEAT_PER - 1)
                                                      : RPT_W'(REPEAT_DLY - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_active <= 1'b0;
      rpt_phase  <= 1'b0;
      rpt_cnt    <= '0;
      press      <= 1'b0;
    end else begin
      press <= edge_hit | rpt_fire;
      if (edge_hit && repeat_en) begin
        rpt_active <= 1'b1;
        rpt_phase  <= 1'b0;
        rpt_cnt    <= '0;
      end else if (!rpt_hold) begin
        rpt_active <= 1'b0;
        rpt_phase  <= 1'b0;
        rpt_cnt    <= '0;
      end else if (rpt_fire) begin
        rpt_phase  <= 1'b1;
        rpt_cnt    <= '0;
      end else begin
        rpt_cnt    <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_rpt_cfg = REPEAT_DLY + REPEAT_PER;
  logic unused_repeat_en;
  assign unused_repeat_en = repeat_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) press <= 1'b0;
    else        press <= edge_hit;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-set mode FSM (RUN/SET_H/SET_M/SET_S) with adjust pulses, blink and timeout.
// Auto-repeat of held up/down buttons is enabled by defining CLOCK_SET_AUTOREPEAT_EN.
`default_nettype none

module clock_set_ctrl #(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000,
  parameter int TIMEOUT_S  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       en_s,
  output logic       up_s,
  output logic       down_s,
  output logic       up_m,
  output logic       down_m,
  output logic       up_h,
  output logic       down_h,
  output logic [1:0] field_sel,
  output logic       blink
);
  import clock_ctrl_pkg::*;

  localparam int TO_W = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);

  state_t          state, state_next;
  logic [TO_W-1:0] to_cnt, to_next;
  logic            blink_next;
  logic [5:0]      adj_pulse, adj_next;
  logic            press_mode, press_up, press_down, press_any;
  logic            in_set, timeout_hit;

  btn_sync_edge #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_mode (
    .clk(clk), .rst_n(rst_n), .btn(btn_mode), .repeat_en(1'b0), .press(press_mode));
  btn_sync_edge #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_up (
    .clk(clk), .rst_n(rst_n), .btn(btn_up), .repeat_en(in_set), .press(press_up));
  btn_sync_edge #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_down (
    .clk(clk), .rst_n(rst_n), .btn(btn_down), .repeat_en(in_set), .press(press_down));

  assign in_set      = (state != RUN);
  assign press_any   = press_mode | press_up | press_down;
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_S));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      to_cnt    <= '0;
      blink     <= 1'b0;
      adj_pulse <= '0;
      field_sel <= FIELD_NONE;
    end else begin
      state     <= state_next;
      to_cnt    <= to_next;
      blink     <= blink_next;
      adj_pulse <= adj_next;
      field_sel <= field_of(state_next);
    end
  end

  always_comb begin
    state_next = state;
    to_next    = to_cnt;
    blink_next = blink;
    adj_next   = '0;

    if (press_mode)                 state_next = advance(state);
    else if (in_set && timeout_hit) state_next = RUN;

    // A mode press or an up+down collision suppresses the adjust pulse.
    if (in_set && !press_mode && (press_up ^ press_down)) begin
      case (state)
        SET_H: begin
          adj_next[ADJ_UP_H]   = press_up;
          adj_next[ADJ_DOWN_H] = press_down;
        end
        SET_M: begin
          adj_next[ADJ_UP_M]   = press_up;
          adj_next[ADJ_DOWN_M] = press_down;
        end
        SET_S: begin
          adj_next[ADJ_UP_S]   = press_up;
          adj_next[ADJ_DOWN_S] = press_down;
        end
        default: adj_next = '0;
      endcase
    end

    // Leaving, entering or sitting in RUN restarts both timeout and blink.
    if (state_next == RUN || state_next != state) begin
      to_next    = '0;
      blink_next = 1'b0;
    end else begin
      if (press_any)                     to_next = '0;
      else if (tick_1hz && !timeout_hit) to_next = to_cnt + 1'b1;
      if (tick_1hz) blink_next = ~blink;
    end
  end

  assign en_s   = (state == RUN) ? tick_1hz : 1'b0;
  assign up_h   = adj_pulse[ADJ_UP_H];
  assign down_h = adj_pulse[ADJ_DOWN_H];
  assign up_m   = adj_pulse[ADJ_UP_M];
  assign down_m = adj_pulse[ADJ_DOWN_M];
  assign up_s   = adj_pulse[ADJ_UP_S];
  assign down_s = adj_pulse[ADJ_DOWN_S];

endmodule

`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed scenarios plus randomized press sequences against a mode/field model.
`default_nettype none
`timescale 1ns/1ps

module tb_clock_set_ctrl;

  logic clk = 1'b0, rst_n = 1'b0, tick_1hz = 1'b0;
  logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic en_s, up_s, down_s, up_m, down_m, up_h, down_h, blink;
  logic [1:0] field_sel;

  int vectors = 0, miscompares = 0;
  int pcnt[6];
  int pfirst[6];
  int onehot_bad;
  int uph_q[$];

  always #5 clk = ~clk;

  clock_set_ctrl #(.REPEAT_DLY(20), .REPEAT_PER(5), .TIMEOUT_S(10)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .en_s(en_s), .up_s(up_s), .down_s(down_s), .up_m(up_m), .down_m(down_m),
    .up_h(up_h), .down_h(down_h), .field_sel(field_sel), .blink(blink));

  // Index order: 0 up_h, 1 down_h, 2 up_m, 3 down_m, 4 up_s, 5 down_s
  function automatic logic [5:0] adj_vec();
    return {down_s, up_s, down_m, up_m, down_h, up_h};
  endfunction

  function automatic int pulse_total();
    int s = 0;
    for (int j = 0; j < 6; j++) s += pcnt[j];
    return s;
  endfunction

  task automatic sample(input int i);
    logic [5:0] v;
    v = adj_vec();
    if ($countones(v) > 1) onehot_bad++;
    for (int j = 0; j < 6; j++)
      if (v[j]) begin
        pcnt[j]++;
        if (pfirst[j] < 0) pfirst[j] = i;
        if (j == 0) uph_q.push_back(i);
      end
  endtask

  // Raise the selected buttons just after an edge, keep them for 'hold' edges,
  // and record every adjust pulse by its edge offset from the drive.
  task automatic apply(input logic m, input logic u, input logic d, input int hold, input int window);
    for (int j = 0; j < 6; j++) begin pcnt[j] = 0; pfirst[j] = -1; end
    onehot_bad = 0;
    uph_q.delete();
    @(posedge clk); #1;
    if (m) btn_mode = 1'b1;
    if (u) btn_up   = 1'b1;
    if (d) btn_down = 1'b1;
    for (int i = 1; i <= window; i++) begin
      @(posedge clk); #1;
      if (i == hold) begin
        if (m) btn_mode = 1'b0;
        if (u) btn_up   = 1'b0;
        if (d) btn_down = 1'b0;
      end
      @(negedge clk);
      sample(i);
    end
  endtask

  task automatic mode_press();
    apply(1'b1, 1'b0, 1'b0, 2, 8);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (field_sel !== 2'd0) begin miscompares++; $display("FAIL reset_field: got %0d want 0", field_sel); end
    vectors++; if (blink !== 1'b0) begin miscompares++; $display("FAIL reset_blink: got %b want 0", blink); end
    vectors++; if (adj_vec() !== 6'b0) begin miscompares++; $display("FAIL reset_adjust: got %b want 000000", adj_vec()); end
    tick_1hz = 1'b1; #1;
    vectors++; if (en_s !== 1'b1) begin miscompares++; $display("FAIL reset_en_s: got %b want 1", en_s); end
    tick_1hz = 1'b0; #1;
    vectors++; if (en_s !== 1'b0) begin miscompares++; $display("FAIL reset_en_s_low: got %b want 0", en_s); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_run_mode();
    int en_err = 0, adj_seen = 0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      tick_1hz = (c % 100 == 50);
      btn_up   = (c >= 120 && c < 145);
      @(negedge clk);
      if (tick_1hz) begin
        vectors++; if (en_s !== 1'b1) begin miscompares++; $display("FAIL run_en_s_tick: got %b want 1 (cycle %0d)", en_s, c); end
      end else if (en_s !== 1'b0) en_err++;
      if (adj_vec() !== 6'b0) adj_seen++;
    end
    tick_1hz = 1'b0; btn_up = 1'b0;
    vectors++; if (en_err != 0) begin miscompares++; $display("FAIL run_en_s_idle: got %0d high cycles want 0", en_err); end
    vectors++; if (adj_seen != 0) begin miscompares++; $display("FAIL run_adjust: got %0d pulse cycles want 0", adj_seen); end
    vectors++; if (field_sel !== 2'd0) begin miscompares++; $display("FAIL run_field: got %0d want 0", field_sel); end
  endtask

  task automatic test_set_hour_up();
    do_reset();
    mode_press();
    vectors++; if (field_sel !== 2'd1) begin miscompares++; $display("FAIL hour_field: got %0d want 1", field_sel); end
    apply(1'b0, 1'b1, 1'b0, 5, 12);
    vectors++; if (pcnt[0] != 1 || pfirst[0] != 4) begin miscompares++; $display("FAIL hour_up_pulse: got count %0d at %0d want 1 at 4", pcnt[0], pfirst[0]); end
    vectors++; if (pulse_total() != 1 || onehot_bad != 0) begin miscompares++; $display("FAIL hour_other_pulses: got total %0d want 1", pulse_total()); end
    @(posedge clk); #1 tick_1hz = 1'b1;
    @(negedge clk);
    vectors++; if (en_s !== 1'b0) begin miscompares++; $display("FAIL hour_en_s: got %b want 0", en_s); end
    @(posedge clk); #1 tick_1hz = 1'b0;
    @(negedge clk);
    vectors++; if (blink !== 1'b1) begin miscompares++; $display("FAIL hour_blink: got %b want 1", blink); end
  endtask

  task automatic test_set_sec_down_simul();
    do_reset();
    repeat (3) mode_press();
    vectors++; if (field_sel !== 2'd3) begin miscompares++; $display("FAIL sec_field: got %0d want 3", field_sel); end
    apply(1'b0, 1'b0, 1'b1, 3, 12);
    vectors++; if (pcnt[5] != 1 || pfirst[5] != 4 || pulse_total() != 1) begin miscompares++; $display("FAIL sec_down_pulse: got count %0d at %0d total %0d want 1 at 4", pcnt[5], pfirst[5], pulse_total()); end
    apply(1'b0, 1'b1, 1'b1, 3, 12);
    vectors++; if (pulse_total() != 0) begin miscompares++; $display("FAIL sec_simul_updown: got %0d pulses want 0", pulse_total()); end
    vectors++; if (field_sel !== 2'd3) begin miscompares++; $display("FAIL sec_field_hold: got %0d want 3", field_sel); end
    apply(1'b1, 1'b1, 1'b0, 3, 12);
    vectors++; if (pulse_total() != 0 || field_sel !== 2'd0) begin miscompares++; $display("FAIL sec_mode_with_up: got %0d pulses field %0d want 0 pulses field 0", pulse_total(), field_sel); end
  endtask

  task automatic test_timeout();
    int toggles = 0;
    logic prevb;
    do_reset();
    repeat (2) mode_press();
    vectors++; if (field_sel !== 2'd2 || blink !== 1'b0) begin miscompares++; $display("FAIL to_entry: got field %0d blink %b want 2 0", field_sel, blink); end
    prevb = blink;
    for (int t = 1; t <= 10; t++)
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1 tick_1hz = (c == 10);
        @(negedge clk);
        if (blink !== prevb) toggles++;
        prevb = blink;
        if (t == 10 && c == 10) begin
          vectors++; if (field_sel !== 2'd2) begin miscompares++; $display("FAIL to_early_exit: got field %0d want 2", field_sel); end
        end
      end
    tick_1hz = 1'b0;
    vectors++; if (field_sel !== 2'd0 || blink !== 1'b0) begin miscompares++; $display("FAIL to_exit: got field %0d blink %b want 0 0", field_sel, blink); end
    vectors++; if (toggles != 10) begin miscompares++; $display("FAIL to_blink_toggles: got %0d want 10", toggles); end
  endtask

  task automatic test_autorepeat();
    int exp_q[$];
`ifdef CLOCK_SET_AUTOREPEAT_EN
    exp_q = '{4, 24, 29, 34, 39};
`else
    exp_q = '{4};
`endif
    do_reset();
    mode_press();
    apply(1'b0, 1'b1, 1'b0, 40, 50);
    vectors++; if (uph_q.size() != exp_q.size() || pulse_total() != exp_q.size()) begin miscompares++; $display("FAIL rpt_count: got %0d up_h (total %0d) want %0d", uph_q.size(), pulse_total(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < uph_q.size(); k++) begin
      vectors++; if (uph_q[k] != exp_q[k]) begin miscompares++; $display("FAIL rpt_offset%0d: got %0d want %0d", k, uph_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid_hold();
    int adj_seen = 0;
    do_reset();
    repeat (3) mode_press();
    @(posedge clk); #1 btn_up = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++; if (up_s !== 1'b1) begin miscompares++; $display("FAIL rmh_pulse_before: got %b want 1", up_s); end
    #1 rst_n = 1'b0; btn_mode = 1'b1;
    #1;
    vectors++; if (adj_vec() !== 6'b0 || field_sel !== 2'd0 || blink !== 1'b0) begin miscompares++; $display("FAIL rmh_async_clear: got adj %b field %0d blink %b want 0", adj_vec(), field_sel, blink); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (adj_vec() !== 6'b0) adj_seen++;
    end
    vectors++; if (field_sel !== 2'd0 || adj_seen != 0) begin miscompares++; $display("FAIL rmh_held_mode: got field %0d pulses %0d want 0 0", field_sel, adj_seen); end
    @(posedge clk); #1 btn_mode = 1'b0;
    repeat (6) @(posedge clk);
    mode_press();
    vectors++; if (field_sel !== 2'd1) begin miscompares++; $display("FAIL rmh_rearm_mode: got field %0d want 1", field_sel); end
    apply(1'b0, 1'b0, 1'b0, 1, 12);
    vectors++; if (pulse_total() != 0) begin miscompares++; $display("FAIL rmh_held_up: got %0d pulses want 0", pulse_total()); end
    @(posedge clk); #1 btn_up = 1'b0;
    repeat (6) @(posedge clk);
    apply(1'b0, 1'b1, 1'b0, 3, 12);
    vectors++; if (pcnt[0] != 1 || pfirst[0] != 4) begin miscompares++; $display("FAIL rmh_repress: got count %0d at %0d want 1 at 4", pcnt[0], pfirst[0]); end
  endtask

  // Model: mode index walks 0..3; in a set field an up/down press yields exactly
  // one pulse on that field's line 4 edges after the drive.
  task automatic test_random();
    int field = 0;
    int exp[6];
    logic m, u, d;
    int hold, sel;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      sel  = $urandom_range(0, 5);
      hold = $urandom_range(1, 8);
      m = (sel == 0 || sel == 4 || sel == 5);
      u = (sel == 1 || sel == 3 || sel == 4);
      d = (sel == 2 || sel == 3 || sel == 5);
      for (int j = 0; j < 6; j++) exp[j] = 0;
      if (m) field = (field + 1) % 4;
      else if (field != 0 && (u != d)) exp[(field - 1) * 2 + (d ? 1 : 0)] = 1;
      apply(m, u, d, hold, hold + 8);
      for (int j = 0; j < 6; j++) begin
        vectors++;
        if (pcnt[j] != exp[j] || (exp[j] == 1 && pfirst[j] != 4)) begin
          miscompares++; $display("FAIL rand_step%0d_out%0d: got count %0d at %0d want %0d at 4", s, j, pcnt[j], pfirst[j], exp[j]);
        end
      end
      vectors++; if (field_sel !== 2'(field) || onehot_bad != 0) begin miscompares++; $display("FAIL rand_step%0d_field: got %0d onehot_bad %0d want %0d", s, field_sel, onehot_bad, field); end
    end
  endtask

  initial begin
    test_reset();
    test_run_mode();
    test_set_hour_up();
    test_set_sec_down_simul();
    test_timeout();
    test_autorepeat();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded, want finish before 2000000", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameters: REPEAT_DLY, default 50_000_000, clk cycles of hold before auto-repeat starts; REPEAT_PER, default 10_000_000, clk cycles between repeat pulses; TIMEOUT_S, default 10, tick_1hz ticks without a button press before set mode exits.
REQ-002 SHALL use one clock `clk`; reset `rst_n` is asynchronous, active-low.
REQ-003 Ports: clk in 1 system clock; rst_n in 1 async active-low reset.
REQ-004 Ports: tick_1hz in 1 one-cycle 1 Hz strobe; btn_mode, btn_up, btn_down in 1 each, asynchronous button levels, debounced, active-high.
REQ-005 Ports: en_s out 1 second-count enable to the time datapath; up_s, down_s, up_m, down_m, up_h, down_h out 1 each, one-cycle adjust pulses.
REQ-006 Ports: field_sel out 2 (0=none, 1=hour, 2=min, 3=sec); blink out 1 display blink for the selected field.

Function
REQ-007 SHALL pass each btn_* through a 2-flop synchronizer, then a rising-edge detector; a press is recognised 3 clk edges after the first edge at which the input is sampled high.
REQ-008 FSM states RUN, SET_H, SET_M, SET_S; a btn_mode press advances RUN->SET_H->SET_M->SET_S->RUN.
REQ-009 In RUN: en_s = tick_1hz (combinational pass-through); all adjust pulses 0; btn_up/btn_down ignored.
REQ-010 In SET_*: en_s = 0; a btn_up press asserts up_x for exactly 1 cycle (x = field of the current state), registered, in the cycle after recognition; btn_down likewise asserts down_x.
REQ-011 btn_up and btn_down recognised in the same cycle: no pulse is emitted.
REQ-012 btn_mode recognised in the same cycle as btn_up or btn_down: the state advances and no adjust pulse is emitted.
REQ-013 At most one of the six adjust outputs is high in any cycle.
REQ-014 Timeout counter SHALL clear on entry to SET_* and on any recognised press, and increment on tick_1hz; when it reaches TIMEOUT_S, the FSM returns to RUN on the next clk edge.
REQ-015 blink SHALL toggle on each tick_1hz while in SET_*, and SHALL be forced to 0 in RUN and on entry to SET_*.
REQ-016 field_sel SHALL be registered and track the state encoding.

Reset
REQ-017 While rst_n = 0: state = RUN, field_sel = 0, blink = 0, all adjust pulses = 0, synchronizer flops = 0, and timeout and repeat counters = 0; en_s follows tick_1hz.
REQ-018 Reset asserted mid-pulse or mid-hold SHALL drop the outputs immediately; a button still held at release does not generate a press until it is released and pressed again.

Configuration
REQ-019 Macro CLOCK_SET_AUTOREPEAT_EN defined: holding btn_up or btn_down in SET_* for REPEAT_DLY cycles after recognition emits one extra pulse, then one pulse every REPEAT_PER cycles until release; each repeat pulse also clears the timeout.
REQ-020 Macro CLOCK_SET_AUTOREPEAT_EN undefined: only edge-recognised pulses are emitted; repeat counters are absent from the netlist.

Structure
REQ-021 Package clock_ctrl_pkg SHALL hold the state enum (RUN, SET_H, SET_M, SET_S) and the field_sel encoding constants.
REQ-022 Sub-module btn_sync_edge SHALL contain the synchronizer, edge detect and (conditional) auto-repeat, and SHALL be instantiated 3 times.

Verification
REQ-023 Reset release, tick_1hz every 100 cycles, no buttons -> state RUN, en_s mirrors every tick, all adjust pulses 0.
REQ-024 btn_mode pulse x1, then btn_up held 5 cycles -> field_sel = 1, en_s = 0, exactly one up_h pulse 4 cycles after btn_up rises.
REQ-025 btn_mode pulses x3, then btn_down, then btn_up and btn_down rising together -> field_sel = 3, one down_s pulse, then no pulse for the simultaneous press.
REQ-026 Enter SET_M with TIMEOUT_S = 10 and no buttons -> return to RUN on the clk edge after the 10th tick; blink toggles 10 times before the exit.
REQ-027 With CLOCK_SET_AUTOREPEAT_EN, REPEAT_DLY = 20 and REPEAT_PER = 5, hold btn_up 40 cycles in SET_H -> up_h pulses at recognition +1, +21, +26, +31, +36; without the macro -> a single pulse.
REQ-028 rst_n asserted while btn_up is held in SET_S -> outputs clear at once; after release of rst_n, with btn_up still high, no up_s pulse is emitted.
